mem_sum_engine: RTL and testbench
=================================

Name: mem_sum_engine

Overview:
Memory-side sequencer that sits directly upstream of the 1024x16 data memory and drives its address, write-data and write-enable inputs. On a start request it reads a block of consecutive words and accumulates their sum and unsigned maximum. It then writes the sum back to a destination word and pulses done. It offloads the array-sum loop from the multicycle datapath.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 16, memory data width
CNT_W, 10, block-length counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request; sampled only in IDLE
base_adr  input  ADDR_W  first word address of block; captured on accepted start
count  input  CNT_W  number of words to read, 0..1023; captured on accepted start
dst_adr  input  ADDR_W  address receiving the sum; captured on accepted start
mem_rdata  input  DATA_W  combinational read data from memory for the current mem_adr
mem_adr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
memwen  output  1  memory write enable; memory writes on the clk edge while high
busy  output  1  high in READ and WRITE
done  output  1  one-cycle pulse after the write-back
sum  output  DATA_W  running/final sum, modulo 2^DATA_W
max  output  DATA_W  running/final unsigned maximum
ovf  output  1  sticky: set if any addition carried out of DATA_W bits

Behaviour:
- Reset (async, immediate): state=IDLE. mem_adr, mem_wdata, sum, max = 0. memwen, busy, done, ovf = 0. Internal pointer, remaining counter and dst register = 0.
- IDLE: memwen=0, busy=0, mem_adr=0.
  - start=1: capture base_adr into ptr, count into rem, dst_adr into dst. Clear sum, max and ovf.
  - Next state is READ if count!=0, otherwise WRITE.
  - sum, max and ovf hold their last values until the next accepted start.
- READ: mem_adr=ptr (registered). Memory read is combinational, so mem_rdata is valid in the same cycle. Each READ cycle, at the edge:
  - sum <= sum + mem_rdata, truncated to DATA_W.
  - ovf <= ovf | carry-out.
  - max <= mem_rdata if mem_rdata > max (unsigned).
  - ptr <= ptr+1, wrapping 1023->0.
  - rem <= rem-1.
  - When rem==1, next state is WRITE.
- WRITE: mem_adr=dst, mem_wdata=sum (final value), memwen=1 for exactly one cycle. Next state is DONE.
- DONE: done=1 for one cycle, memwen=0, busy=0, mem_adr=0. Next state is IDLE.
- Outputs mem_adr, mem_wdata, memwen, busy and done are decoded from registered state and registers only; no combinational path from start or mem_rdata to any output.
- Latency: start accepted at edge E0. READ cycles are E0+1..E0+N. WRITE occupies cycle N+1; done is high in cycle N+2. Total N+2 cycles from start to done; count=0 gives WRITE at cycle 1 and done at cycle 2.
- start while not IDLE (including DONE): ignored. No queuing; inputs are not re-captured.
- Address wrap: a block crossing 1023 continues at 0.
- dst inside the block being read: allowed. The write occurs after all reads, so no hazard.
- Reset mid-operation: abort immediately, memwen drops asynchronously, no write-back, no done pulse.
- mem_wdata outside WRITE is 0.

Test Plan:
- Memory preloaded m[100..109]=1..10; start with base=100, count=10, dst=200 -> busy for 11 cycles, mem_adr steps 100..109, then one memwen with mem_adr=200 and mem_wdata=55. done pulses at cycle 12. m[200]=55, sum=55, max=10, ovf=0.
- count=0, dst=300 -> no READ cycles; WRITE in cycle 1 writes m[300]=0; done in cycle 2; sum=0, max=0.
- Wrap: m[1022]=1, m[1023]=2, m[0]=3, m[1]=4; base=1022, count=4 -> mem_adr sequence 1022,1023,0,1; sum=10, max=4.
- Overflow: m[50]=16'hFFFF, m[51]=16'h0003; base=50, count=2 -> sum=16'h0002, ovf=1, max=16'hFFFF, written to dst.
- Start pulsed again during READ with different base/count -> ignored; the original result is unchanged; exactly one done pulse.
- rst asserted during READ of a 10-word block -> memwen=0, busy=0, sum=0 immediately; m[dst] unchanged; no done pulse. A new start after release runs normally.

Source files
------------

// File: rtl/mem_sum_engine.sv
// Block-sum sequencer: reads count words from base, accumulates sum and unsigned max,
// writes the sum to dst, then pulses done. Outputs decode from registered state only.
module mem_sum_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] dst_adr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              memwen,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] max,
    output logic              ovf
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  rem;
    logic [DATA_W:0]   add_full;

    // Extra bit keeps the carry-out for the sticky overflow flag.
    assign add_full = {1'b0, sum} + {1'b0, mem_rdata};

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (count != '0) ? READ : WRITE;
            READ:  if (rem == CNT_W'(1)) state_nxt = WRITE;
            WRITE: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            rem <= '0;
            dst <= '0;
            sum <= '0;
            max <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr <= base_adr;
                        rem <= count;
                        dst <= dst_adr;
                        sum <= '0;
                        max <= '0;
                        ovf <= 1'b0;
                    end
                end
                READ: begin
                    sum <= add_full[DATA_W-1:0];
                    ovf <= ovf | add_full[DATA_W];
                    if (mem_rdata > max) max <= mem_rdata;
                    // Natural ADDR_W-bit rollover gives the 1023->0 wrap.
                    ptr <= ptr + ADDR_W'(1);
                    rem <= rem - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        memwen    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            READ: begin
                mem_adr = ptr;
                busy    = 1'b1;
            end
            WRITE: begin
                mem_adr   = dst;
                mem_wdata = sum;
                memwen    = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_sum_engine.sv
// Table-driven bench for mem_sum_engine with a 1024x16 behavioural memory model
// and hand-written sequences for reset abort and ignored starts.
module tb_mem_sum_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_adr = '0;
    logic [9:0]  count = '0;
    logic [9:0]  dst_adr = '0;
    logic [15:0] mem_rdata;
    logic [9:0]  mem_adr;
    logic [15:0] mem_wdata;
    logic        memwen, busy, done, ovf;
    logic [15:0] sum, max;

    logic [15:0] mem [1024];
    logic        loaded = 1'b0;

    int compared = 0;
    int mismatched = 0;

    mem_sum_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_adr  (base_adr),
        .count     (count),
        .dst_adr   (dst_adr),
        .mem_rdata (mem_rdata),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .memwen    (memwen),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .max       (max),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr];

    // Preload on the first edge (reset is held), then act as the synchronous write port.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            for (int i = 0; i < 10; i++) mem[100 + i] <= 16'(i + 1);
            mem[1022] <= 16'd1;
            mem[1023] <= 16'd2;
            mem[0]    <= 16'd3;
            mem[1]    <= 16'd4;
            mem[50]   <= 16'hFFFF;
            mem[51]   <= 16'h0003;
            mem[300]  <= 16'hBEEF;
            loaded    <= 1'b1;
        end else if (memwen) begin
            mem[mem_adr] <= mem_wdata;
        end
    end

    typedef struct {
        logic [9:0]  base;
        logic [9:0]  cnt;
        logic [9:0]  dst;
        logic [15:0] e_sum;
        logic [15:0] e_max;
        logic        e_ovf;
        int          poke;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation and checks every cycle through two cycles past done.
    // A nonzero poke pulses a conflicting start in that cycle, which must be ignored.
    task automatic run_op(input vec_t v, input int id);
        int         n;
        int         dones;
        logic [9:0] exp_adr;
        n     = int'(v.cnt);
        dones = 0;
        @(negedge clk);
        base_adr = v.base;
        count    = v.cnt;
        dst_adr  = v.dst;
        start    = 1'b1;
        for (int k = 1; k <= n + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k <= n) begin
                exp_adr = v.base + 10'(k - 1);
                check($sformatf("v%0d c%0d read adr", id, k), 32'(mem_adr), 32'(exp_adr));
                check($sformatf("v%0d c%0d read busy", id, k), 32'(busy), 32'd1);
                check($sformatf("v%0d c%0d read memwen/wdata", id, k),
                      {15'd0, memwen, mem_wdata}, 32'd0);
            end else if (k == n + 1) begin
                check($sformatf("v%0d write memwen", id), 32'(memwen), 32'd1);
                check($sformatf("v%0d write adr", id), 32'(mem_adr), 32'(v.dst));
                check($sformatf("v%0d write data", id), 32'(mem_wdata), 32'(v.e_sum));
                check($sformatf("v%0d write busy", id), 32'(busy), 32'd1);
            end else if (k == n + 2) begin
                check($sformatf("v%0d done", id), 32'(done), 32'd1);
                check($sformatf("v%0d done busy/memwen", id), {busy, memwen}, 32'd0);
            end else begin
                check($sformatf("v%0d c%0d idle busy", id, k), 32'(busy), 32'd0);
            end
            if (done) dones++;
            if (k == v.poke) begin
                base_adr = 10'd50;
                count    = 10'd2;
                dst_adr  = 10'd220;
                start    = 1'b1;
            end
        end
        check($sformatf("v%0d done pulses", id), 32'(dones), 32'd1);
        check($sformatf("v%0d sum", id), 32'(sum), 32'(v.e_sum));
        check($sformatf("v%0d max", id), 32'(max), 32'(v.e_max));
        check($sformatf("v%0d ovf", id), 32'(ovf), 32'(v.e_ovf));
        check($sformatf("v%0d mem[dst]", id), 32'(mem[v.dst]), 32'(v.e_sum));
    endtask

    initial begin
        int dones;

        vecs[0] = '{10'd100,  10'd10, 10'd200, 16'd55,     16'd10,     1'b0, 0};
        vecs[1] = '{10'd0,    10'd0,  10'd300, 16'd0,      16'd0,      1'b0, 2};
        vecs[2] = '{10'd1022, 10'd4,  10'd500, 16'd10,     16'd4,      1'b0, 0};
        vecs[3] = '{10'd50,   10'd2,  10'd600, 16'h0002,   16'hFFFF,   1'b1, 0};
        vecs[4] = '{10'd100,  10'd10, 10'd210, 16'd55,     16'd10,     1'b0, 3};
        vecs[5] = '{10'd100,  10'd10, 10'd105, 16'd55,     16'd10,     1'b0, 0};

        #1;
        check("reset outputs", {memwen, busy, done, ovf, 28'd0}, 32'd0);
        check("reset adr/wdata", {6'd0, mem_adr, mem_wdata}, 32'd0);
        check("reset sum/max", {sum, max}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_op(vecs[i], i);
        check("ignored start target untouched", 32'(mem[220]), 32'd0);

        // Abort mid-READ: everything clears at once, no write-back, no done.
        @(negedge clk);
        base_adr = 10'd1022;
        count    = 10'd10;
        dst_adr  = 10'd230;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort busy/memwen/done", {busy, memwen, done}, 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort adr", 32'(mem_adr), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("post-abort activity", 32'(dones), 32'd0);
        check("post-abort mem[dst]", 32'(mem[230]), 32'd0);

        run_op(vecs[3], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
